// File: rtl/vga_timing_pkg.sv
// Shared raster constants, the coordinate type and flag helpers used by the
// timing generator and by every renderer that consumes its counters.
package vga_timing_pkg;

    localparam int unsigned COORD_W       = 10;
    localparam int unsigned VGA_PARAM_MAX = (1 << COORD_W) - 1;

    typedef logic [COORD_W-1:0] coord_t;

    // 640x480 at 60 Hz from a 100 MHz system clock
    localparam int unsigned VGA_CLK_DIV         = 4;
    localparam int unsigned VGA_H_TOTAL         = 800;
    localparam int unsigned VGA_H_SYNC          = 96;
    localparam int unsigned VGA_H_ACT_START     = 144;
    localparam int unsigned VGA_H_ACT_END       = 783;
    localparam int unsigned VGA_V_TOTAL         = 521;
    localparam int unsigned VGA_V_SYNC          = 2;
    localparam int unsigned VGA_V_ACT_START     = 31;
    localparam int unsigned VGA_V_ACT_END       = 510;
    localparam int unsigned VGA_FRAMES_PER_TICK = 60;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_flags_t;

    function automatic logic in_window(coord_t c, coord_t lo, coord_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Syncs are active-low: they sit low while the coordinate is below the sync width.
    function automatic sync_flags_t calc_flags(
        coord_t h, coord_t v,
        coord_t h_sync, coord_t v_sync,
        coord_t h_lo, coord_t h_hi,
        coord_t v_lo, coord_t v_hi
    );
        sync_flags_t f;
        f.hsync    = (h >= h_sync);
        f.vsync    = (v >= v_sync);
        f.video_on = in_window(h, h_lo, h_hi) && in_window(v, v_lo, v_hi);
        return f;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the generator drives it, renderers and the VGA pins read it.
interface vga_timing_gen_if;

    logic                    pix_en;
    vga_timing_pkg::coord_t  h_count;
    vga_timing_pkg::coord_t  v_count;
    logic                    hsync;
    logic                    vsync;
    logic                    video_on;
    logic                    frame_start;
    logic                    clk_1s;

    modport master (
        output pix_en, h_count, v_count, hsync, vsync,
               video_on, frame_start, clk_1s
    );

    modport slave (
        input  pix_en, h_count, v_count, hsync, vsync,
               video_on, frame_start, clk_1s
    );

endinterface

// File: rtl/clk_en_div.sv
// Rate divider producing a registered one-clk enable pulse every CLK_DIV clocks.
module clk_en_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic en
);

    logic r_en;

    generate
        if (CLK_DIV <= 1) begin : g_every_clk
            // Registered so the enable is still low while reset is held.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_en <= 1'b0;
                end else begin
                    r_en <= 1'b1;
                end
            end
        end else begin : g_count
            localparam int unsigned DIV_W = $clog2(CLK_DIV);
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

            logic [DIV_W-1:0] r_div;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_div <= '0;
                    r_en  <= 1'b0;
                end else begin
                    r_en  <= (r_div == DIV_LAST);
                    r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
                end
            end
        end
    endgenerate

    assign en = r_en;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel counters, registered sync/visible flags,
// frame-start pulse and the frame-derived clk_1s animation tick.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV         = VGA_CLK_DIV,
    parameter int unsigned H_TOTAL         = VGA_H_TOTAL,
    parameter int unsigned H_SYNC          = VGA_H_SYNC,
    parameter int unsigned H_ACT_START     = VGA_H_ACT_START,
    parameter int unsigned H_ACT_END       = VGA_H_ACT_END,
    parameter int unsigned V_TOTAL         = VGA_V_TOTAL,
    parameter int unsigned V_SYNC          = VGA_V_SYNC,
    parameter int unsigned V_ACT_START     = VGA_V_ACT_START,
    parameter int unsigned V_ACT_END       = VGA_V_ACT_END,
    parameter int unsigned FRAMES_PER_TICK = VGA_FRAMES_PER_TICK
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vga_timing_gen_if.master        o_vga
);

    localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
    localparam coord_t H_SYN_C = coord_t'(H_SYNC);
    localparam coord_t V_SYN_C = coord_t'(V_SYNC);
    localparam coord_t H_LO    = coord_t'(H_ACT_START);
    localparam coord_t H_HI    = coord_t'(H_ACT_END);
    localparam coord_t V_LO    = coord_t'(V_ACT_START);
    localparam coord_t V_HI    = coord_t'(V_ACT_END);
    localparam coord_t FC_LAST = coord_t'(FRAMES_PER_TICK / 2 - 1);

    logic        w_pix_en;
    logic        w_line_end;
    logic        w_frame_end;
    coord_t      w_h_next;
    coord_t      w_v_next;
    sync_flags_t w_flags_next;

    coord_t      r_h;
    coord_t      r_v;
    coord_t      r_fcnt;
    sync_flags_t r_flags;
    logic        r_frame_start;
    logic        r_clk_1s;

    clk_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_pix_en)
    );

    // Flags are derived from the next counter values so they land on the
    // same edge as the counters themselves.
    always_comb begin
        w_line_end   = (r_h == H_LAST);
        w_frame_end  = w_line_end && (r_v == V_LAST);
        w_h_next     = w_line_end ? '0 : r_h + coord_t'(1);
        w_v_next     = r_v;
        if (w_line_end) begin
            w_v_next = (r_v == V_LAST) ? '0 : r_v + coord_t'(1);
        end
        w_flags_next = calc_flags(w_h_next, w_v_next, H_SYN_C, V_SYN_C,
                                  H_LO, H_HI, V_LO, V_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h           <= '0;
            r_v           <= '0;
            r_fcnt        <= '0;
            r_flags       <= '0;
            r_frame_start <= 1'b0;
            r_clk_1s      <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_pix_en) begin
                r_h     <= w_h_next;
                r_v     <= w_v_next;
                r_flags <= w_flags_next;
                if (w_frame_end) begin
                    r_frame_start <= 1'b1;
                    if (r_fcnt == FC_LAST) begin
                        r_fcnt   <= '0;
                        r_clk_1s <= ~r_clk_1s;
                    end else begin
                        r_fcnt <= r_fcnt + coord_t'(1);
                    end
                end
            end
        end
    end

    assign o_vga.pix_en      = w_pix_en;
    assign o_vga.h_count     = r_h;
    assign o_vga.v_count     = r_v;
    assign o_vga.hsync       = r_flags.hsync;
    assign o_vga.vsync       = r_flags.vsync;
    assign o_vga.video_on    = r_flags.video_on;
    assign o_vga.frame_start = r_frame_start;
    assign o_vga.clk_1s      = r_clk_1s;

    // Parameters must fit the 10-bit coordinate space and give a symmetric tick.
    always @(posedge clk) begin
        param_legal : assert (
            (CLK_DIV >= 1) && (CLK_DIV <= VGA_PARAM_MAX) &&
            (H_TOTAL >= 1) && (H_TOTAL <= VGA_PARAM_MAX) &&
            (H_SYNC <= VGA_PARAM_MAX) &&
            (H_ACT_START <= VGA_PARAM_MAX) && (H_ACT_END <= VGA_PARAM_MAX) &&
            (V_TOTAL >= 1) && (V_TOTAL <= VGA_PARAM_MAX) &&
            (V_SYNC <= VGA_PARAM_MAX) &&
            (V_ACT_START <= VGA_PARAM_MAX) && (V_ACT_END <= VGA_PARAM_MAX) &&
            (FRAMES_PER_TICK >= 2) && (FRAMES_PER_TICK <= VGA_PARAM_MAX) &&
            ((FRAMES_PER_TICK % 2) == 0)
        );
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Produces the 640x480 raster timing that drives the VGA output and every renderer in the RPG display path, including the background, sprite and overlay blocks.
- Divides the system clock down to a pixel-rate enable and runs the horizontal and vertical pixel counters.
- Generates active-low hsync/vsync, a visible-area flag and a frame-start pulse.
- Derives the slow `clk_1s` animation tick that the tile animators count on.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel; 100 MHz to 25 MHz. Legal range is 1 or more.
- `H_TOTAL`, 800: clocks per line (pixel periods).
- `H_SYNC`, 96: hsync low width.
- `H_ACT_START`, 144: first visible column.
- `H_ACT_END`, 783: last visible column.
- `V_TOTAL`, 521: lines per frame.
- `V_SYNC`, 2: vsync low width, in lines.
- `V_ACT_START`, 31: first visible line.
- `V_ACT_END`, 510: last visible line.
- `FRAMES_PER_TICK`, 60: frames per `clk_1s` period. Must be even and 2 or more.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `pix_en`, out, 1: one-`clk` pulse per pixel period.
- `h_count`, out, 10: column, 0..H_TOTAL-1.
- `v_count`, out, 10: line, 0..V_TOTAL-1.
- `hsync`, out, 1: active-low horizontal sync.
- `vsync`, out, 1: active-low vertical sync.
- `video_on`, out, 1: high inside the visible window.
- `frame_start`, out, 1: one-`clk` pulse when the counters wrap to (0,0).
- `clk_1s`, out, 1: 50%-duty tick, period FRAMES_PER_TICK frames.

## Operation
Pixel-enable divider:
- `div` counts 0..CLK_DIV-1 on every `clk`.
- `pix_en` is high when `div` = CLK_DIV-1.
- With CLK_DIV=1, `pix_en` is constantly high after reset.

Horizontal counter:
- Advances only on `pix_en`.
- At H_TOTAL-1 it wraps to 0, and `v_count` advances on that same edge.

Vertical counter:
- Wraps at V_TOTAL-1.
- The wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0) asserts `frame_start` for exactly one `clk`.

Sync and visible flags (all registered, all computed from the next-state counter values):
- `hsync` = 0 when h_count < H_SYNC.
- `vsync` = 0 when v_count < V_SYNC.
- `video_on` = 1 when H_ACT_START ≤ h_count ≤ H_ACT_END and V_ACT_START ≤ v_count ≤ V_ACT_END.
- These flags therefore always match the `h_count`/`v_count` values on the same cycle.

Tick generator:
- A frame counter `fcnt` runs 0..FRAMES_PER_TICK/2-1 and increments on each `frame_start`.
- When `fcnt` wraps, `clk_1s` toggles.
- `clk_1s` is a registered data signal in the `clk` domain. Consumers that use it as a clock accept the resulting skew.

Width rules:
- All comparisons are unsigned, 10-bit.
- Parameter values greater than 1023 are illegal; this is checked by a simulation assertion.

## Timing
Reset (asynchronous assert, synchronous release on `clk`):
- `div`=0, `h_count`=0, `v_count`=0, `fcnt`=0.
- `pix_en`=0, `frame_start`=0, `clk_1s`=0, `video_on`=0.
- `hsync`=0 and `vsync`=0, because (0,0) lies inside both sync regions.

Release:
- The first `pix_en` comes CLK_DIV `clk` edges after `rst_n` rises.
- The first counter advance is on that edge.

Latency:
- `h_count`, `v_count` and all flags update on the same `clk` edge where `pix_en` is high, so there is zero relative skew between them.
- Downstream ROM lookups add their own one-cycle latency.

Frame and tick arithmetic:
- Frame length = H_TOTAL·V_TOTAL·CLK_DIV clocks; 1,667,200 with the default parameters.
- `clk_1s` toggles every FRAMES_PER_TICK/2 frames.

Reset mid-frame:
- All state returns to its reset value immediately.
- No `frame_start` pulse is generated by the reset.

Simultaneous line wrap and frame wrap:
- Handled in one edge.
- `frame_start`, `v_count`=0 and the `fcnt` increment all occur together.

## Structure
- **`vga_timing_pkg`:** holds the default timing constants (H_TOTAL, H_SYNC, H_ACT_START/END, V_TOTAL, V_SYNC, V_ACT_START/END), and the 10-bit `coord_t` type shared with the renderers.
- **`clk_en_div` sub-module:** parameter CLK_DIV; ports `clk`, `rst_n`, `en`. It is reused by other rate-divided blocks.
- **Top level:** counters, flags and tick logic live in `vga_timing_gen`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-line at (h=400, v=200). Expect all outputs at reset values on the same cycle: `hsync`=0, `vsync`=0, `video_on`=0, `clk_1s`=0. After release, the first `pix_en` comes 4 clocks later.
- **Pixel cadence:** with CLK_DIV=4, `pix_en` is high exactly one clock in 4. With CLK_DIV=1 it is high every clock, and `h_count` advances each clock.
- **Line timing:**
  - `hsync` is low for h 0..95 and high for h 96..799.
  - `h_count` goes 799→0 with `v_count` incrementing on the same edge.
  - `video_on` rises at (144,31) and falls at (784,31).
- **Frame wrap:**
  - At (799,520), the next pixel gives (0,0) with a single-clock `frame_start`.
  - `vsync` is low for lines 0..1 only.
  - The frame measures 1,667,200 clocks.
- **Tick:** with FRAMES_PER_TICK=4, `clk_1s` toggles after every 2 `frame_start` pulses, giving a period of 4 frames at 50% duty.
- **Visible box:** scan a full frame and count `video_on` clocks. Expect 640×480×CLK_DIV = 1,228,800.
